// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - chess game-flow FSM: turn alternation, move-mask request, board commit, chess clock
module turn_sequencer #(
    parameter int CLK_HZ       = 65_000_000,
    parameter int TURN_SECONDS = 600,
    parameter int SEC_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pick_valid,
    input  logic [5:0]       pick_sq,
    input  logic             pick_empty,
    input  logic             pick_color,
    input  logic             place_valid,
    input  logic [5:0]       place_sq,
    output logic             movegen_req,
    output logic [5:0]       movegen_sq,
    input  logic             movegen_done,
    input  logic [63:0]      possible_moves,
    output logic             bw_en,
    output logic [5:0]       bw_from,
    output logic [5:0]       bw_to,
    input  logic             bw_ack,
    output logic             side,
    output logic             begin_turn,
    output logic             sel_valid,
    output logic [63:0]      sel_moves,
    output logic [SEC_W-1:0] time_w,
    output logic [SEC_W-1:0] time_b,
    output logic             game_over,
    output logic             winner
);
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_PICK, S_GEN, S_WAIT_PLACE, S_COMMIT, S_SWITCH, S_OVER
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] presc;
    logic [5:0]       picked;
    logic             clock_run;
    logic             tick;
    logic [SEC_W-1:0] active_time;
    logic             flag_fall;

    assign movegen_sq  = picked;
    assign bw_from     = picked;
    assign clock_run   = (state == S_WAIT_PICK) || (state == S_GEN) ||
                         (state == S_WAIT_PLACE) || (state == S_COMMIT);
    assign tick        = clock_run && (presc == PRE_W'(CLK_HZ - 1));
    assign active_time = side ? time_b : time_w;
    // Only the 1->0 transition ends the game; a counter already at 0 just saturates.
    assign flag_fall   = tick && (active_time == SEC_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            presc       <= '0;
            picked      <= '0;
            movegen_req <= 1'b0;
            bw_en       <= 1'b0;
            bw_to       <= '0;
            side        <= 1'b0;
            begin_turn  <= 1'b0;
            sel_valid   <= 1'b0;
            sel_moves   <= '0;
            time_w      <= SEC_W'(TURN_SECONDS);
            time_b      <= SEC_W'(TURN_SECONDS);
            game_over   <= 1'b0;
            winner      <= 1'b0;
        end else begin
            begin_turn <= 1'b0;
            if (start) begin
                state       <= S_WAIT_PICK;
                presc       <= '0;
                movegen_req <= 1'b0;
                bw_en       <= 1'b0;
                side        <= 1'b0;
                begin_turn  <= 1'b1;
                sel_valid   <= 1'b0;
                sel_moves   <= '0;
                time_w      <= SEC_W'(TURN_SECONDS);
                time_b      <= SEC_W'(TURN_SECONDS);
                game_over   <= 1'b0;
                winner      <= 1'b0;
            end else begin
                if (clock_run) begin
                    presc <= tick ? '0 : presc + PRE_W'(1);
                    if (tick && active_time != '0) begin
                        if (side) time_b <= time_b - SEC_W'(1);
                        else      time_w <= time_w - SEC_W'(1);
                    end
                end
                // Flag fall pre-empts every pick/place/done/ack in the same cycle.
                if (flag_fall) begin
                    state       <= S_OVER;
                    game_over   <= 1'b1;
                    winner      <= ~side;
                    movegen_req <= 1'b0;
                    bw_en       <= 1'b0;
                    sel_valid   <= 1'b0;
                    sel_moves   <= '0;
                end else begin
                    case (state)
                        S_WAIT_PICK: begin
                            if (pick_valid && !pick_empty && pick_color == side) begin
                                picked      <= pick_sq;
                                movegen_req <= 1'b1;
                                state       <= S_GEN;
                            end
                        end
                        S_GEN: begin
                            if (movegen_done) begin
                                movegen_req <= 1'b0;
                                if (possible_moves == '0) begin
                                    state <= S_WAIT_PICK;
                                end else begin
                                    sel_valid <= 1'b1;
                                    sel_moves <= possible_moves;
                                    state     <= S_WAIT_PLACE;
                                end
                            end
                        end
                        S_WAIT_PLACE: begin
                            if (place_valid) begin
                                if (place_sq == picked) begin
                                    sel_valid <= 1'b0;
                                    sel_moves <= '0;
                                    state     <= S_WAIT_PICK;
                                end else if (sel_moves[place_sq]) begin
                                    bw_to <= place_sq;
                                    bw_en <= 1'b1;
                                    state <= S_COMMIT;
                                end
                            end
                        end
                        S_COMMIT: begin
                            if (bw_ack) begin
                                bw_en <= 1'b0;
                                state <= S_SWITCH;
                            end
                        end
                        S_SWITCH: begin
                            side       <= ~side;
                            presc      <= '0;
                            sel_valid  <= 1'b0;
                            sel_moves  <= '0;
                            begin_turn <= 1'b1;
                            state      <= S_WAIT_PICK;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_turn_sequencer.sv
// tb/tb_turn_sequencer.sv - directed self-checking bench for turn_sequencer
module tb_turn_sequencer;
    localparam int SEC_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             pick_valid;
    logic [5:0]       pick_sq;
    logic             pick_empty;
    logic             pick_color;
    logic             place_valid;
    logic [5:0]       place_sq;
    logic             movegen_req;
    logic [5:0]       movegen_sq;
    logic             movegen_done;
    logic [63:0]      possible_moves;
    logic             bw_en;
    logic [5:0]       bw_from;
    logic [5:0]       bw_to;
    logic             bw_ack;
    logic             side;
    logic             begin_turn;
    logic             sel_valid;
    logic [63:0]      sel_moves;
    logic [SEC_W-1:0] time_w;
    logic [SEC_W-1:0] time_b;
    logic             game_over;
    logic             winner;

    int checks   = 0;
    int failures = 0;

    turn_sequencer #(.CLK_HZ(10), .TURN_SECONDS(3), .SEC_W(SEC_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pick_valid(pick_valid), .pick_sq(pick_sq), .pick_empty(pick_empty), .pick_color(pick_color),
        .place_valid(place_valid), .place_sq(place_sq),
        .movegen_req(movegen_req), .movegen_sq(movegen_sq), .movegen_done(movegen_done),
        .possible_moves(possible_moves),
        .bw_en(bw_en), .bw_from(bw_from), .bw_to(bw_to), .bw_ack(bw_ack),
        .side(side), .begin_turn(begin_turn), .sel_valid(sel_valid), .sel_moves(sel_moves),
        .time_w(time_w), .time_b(time_b), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic do_pick(input logic [5:0] sq, input logic empty, input logic color);
        pick_valid = 1'b1; pick_sq = sq; pick_empty = empty; pick_color = color;
        step();
        pick_valid = 1'b0;
    endtask

    task automatic do_done(input logic [63:0] mask);
        movegen_done = 1'b1; possible_moves = mask;
        step();
        movegen_done = 1'b0; possible_moves = '0;
    endtask

    task automatic do_place(input logic [5:0] sq);
        place_valid = 1'b1; place_sq = sq;
        step();
        place_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 0; pick_valid = 0; pick_sq = 0; pick_empty = 0; pick_color = 0;
        place_valid = 0; place_sq = 0; movegen_done = 0; possible_moves = 0; bw_ack = 0;
        step(2);
        rst = 1'b0;
        check_eq("rst_time_w", time_w, 3);
        check_eq("rst_time_b", time_b, 3);
        check_eq("rst_outs", {side, begin_turn, sel_valid, movegen_req, bw_en, game_over, winner}, 0);
        step(3);
        check_eq("idle_time_w", time_w, 3);

        // full move: white 12 -> 28
        do_start();
        check_eq("start_begin_turn", begin_turn, 1);
        do_pick(6'd12, 1'b0, 1'b0);
        check_eq("pick_req", movegen_req, 1);
        check_eq("pick_sq", movegen_sq, 12);
        do_done(64'd1 << 28);
        check_eq("gen_sel_valid", sel_valid, 1);
        check_eq("gen_sel_moves", sel_moves, 64'd1 << 28);
        check_eq("gen_req_drop", movegen_req, 0);
        do_place(6'd28);
        check_eq("commit_bw", {bw_en, bw_from, bw_to}, {1'b1, 6'd12, 6'd28});
        step(2);
        check_eq("commit_hold", bw_en, 1);
        bw_ack = 1'b1; step(); bw_ack = 1'b0;
        check_eq("ack_bw_drop", {bw_en, begin_turn}, 0);
        step();
        check_eq("switch_pulse", {begin_turn, side, sel_valid}, 3'b110);
        check_eq("switch_sel_moves", sel_moves, 0);
        step();
        check_eq("switch_pulse_end", begin_turn, 0);

        // illegal picks for white
        do_start();
        do_pick(6'd50, 1'b0, 1'b1);
        check_eq("pick_wrong_color", movegen_req, 0);
        do_pick(6'd20, 1'b1, 1'b0);
        check_eq("pick_empty", movegen_req, 0);
        do_done(64'd1 << 5);
        check_eq("stray_done", sel_valid, 0);

        // empty mask, then cancel
        do_start();
        do_pick(6'd8, 1'b0, 1'b0);
        do_done(64'd0);
        check_eq("mask0_back", {movegen_req, sel_valid}, 0);
        do_pick(6'd8, 1'b0, 1'b0);
        check_eq("repick_req", movegen_req, 1);
        do_done(64'd1 << 16);
        check_eq("repick_sel", sel_valid, 1);
        do_place(6'd8);
        check_eq("cancel_sel", {sel_valid, side, bw_en}, 0);
        check_eq("cancel_moves", sel_moves, 0);
        do_place(6'd16);
        check_eq("place_after_cancel", bw_en, 0);

        // illegal place ignored, then start aborts the commit
        do_start();
        do_pick(6'd12, 1'b0, 1'b0);
        do_done(64'd1 << 28);
        do_place(6'd20);
        check_eq("illegal_place", {bw_en, sel_valid}, 2'b01);
        do_place(6'd28);
        check_eq("legal_place", bw_en, 1);
        step(8);
        check_eq("commit_time_w", time_w, 2);
        do_start();
        check_eq("abort_start", {bw_en, side, begin_turn}, 3'b001);
        check_eq("abort_time_w", time_w, 3);
        bw_ack = 1'b1; step(); bw_ack = 1'b0;
        step();
        check_eq("abort_stray_ack", {begin_turn, side}, 0);

        // white flag falls while idle
        do_start();
        step(9);
        check_eq("clk_t9", time_w, 3);
        step(1);
        check_eq("clk_t10", time_w, 2);
        step(10);
        check_eq("clk_t20", time_w, 1);
        step(9);
        check_eq("clk_t29", {game_over, time_w}, {1'b0, 4'd1});
        step(1);
        check_eq("flag_time_w", time_w, 0);
        check_eq("flag_over", {game_over, winner}, 2'b11);
        check_eq("flag_time_b", time_b, 3);
        do_pick(6'd12, 1'b0, 1'b0);
        check_eq("over_pick", movegen_req, 0);
        step(15);
        check_eq("over_frozen", {time_w, time_b, game_over}, {4'd0, 4'd3, 1'b1});

        // flag fall during commit beats a same-cycle ack
        do_start();
        do_pick(6'd12, 1'b0, 1'b0);
        do_done(64'd1 << 28);
        do_place(6'd28);
        step(26);
        check_eq("late_commit", bw_en, 1);
        bw_ack = 1'b1; step(); bw_ack = 1'b0;
        check_eq("flag_commit", {bw_en, game_over, winner}, 3'b011);
        step();
        check_eq("flag_commit_noswitch", {begin_turn, side}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
